// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage_if
//  Purpose  : MEM-to-WB bundle (stage controls, MEM results, regfile write
//             port, forwarding tap and retire counter) for wb_stage.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic             m_valid;
  logic             m_regwrite;
  logic [4:0]       m_rd;
  logic [1:0]       m_resultsrc;
  logic [2:0]       m_funct3;
  logic [XLEN-1:0]  m_aluresult;
  logic [XLEN-1:0]  m_rdata;
  logic [XLEN-1:0]  m_pcplus4;

  logic             we3;
  logic [4:0]       a3;
  logic [XLEN-1:0]  wd3;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             misalign;
  logic [CNT_W-1:0] retired;

  // Pipeline side: produces MEM results, consumes the writeback port.
  modport master (
    output stall, flush, m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3,
           m_aluresult, m_rdata, m_pcplus4,
    input  we3, a3, wd3, fwd_valid, fwd_rd, fwd_data, misalign, retired
  );

  // Writeback stage.
  modport slave (
    input  stall, flush, m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3,
           m_aluresult, m_rdata, m_pcplus4,
    output we3, a3, wd3, fwd_valid, fwd_rd, fwd_data, misalign, retired
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : RV32I MEM/WB register, load extraction, writeback select,
//             forwarding tap and retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  wire        clk,
  input  wire        rst_n,
  wb_stage_if.slave  bus
);

  localparam logic [1:0] c_SRC_ALU  = 2'b00;
  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [1:0] c_SRC_PC4  = 2'b10;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  logic             r_valid;
  logic             r_regwrite;
  logic [4:0]       r_rd;
  logic [1:0]       r_resultsrc;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_aluresult;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  r_pcplus4;
  logic [CNT_W-1:0] r_retired;

  logic [1:0]       w_off;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_word;
  logic [XLEN-1:0]  w_load;
  logic             w_mis_cond;
  logic             w_misalign;
  logic             w_we;
  logic [XLEN-1:0]  w_sel;
  logic             w_advance;

  // ---------------------------------------------------------------------------
  // MEM/WB register: flush beats stall; a flushed slot keeps stale payload.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_rd        <= '0;
      r_resultsrc <= '0;
      r_funct3    <= '0;
      r_aluresult <= '0;
      r_rdata     <= '0;
      r_pcplus4   <= '0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
    end else if (!bus.stall) begin
      r_valid     <= bus.m_valid;
      r_regwrite  <= bus.m_regwrite;
      r_rd        <= bus.m_rd;
      r_resultsrc <= bus.m_resultsrc;
      r_funct3    <= bus.m_funct3;
      r_aluresult <= bus.m_aluresult;
      r_rdata     <= bus.m_rdata;
      r_pcplus4   <= bus.m_pcplus4;
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the aligned memory word.
  // ---------------------------------------------------------------------------
  assign w_off = r_aluresult[1:0];

  always_comb begin
    w_byte = r_rdata[7:0];
    case (w_off)
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
  end

  assign w_half = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];

  generate
    if (XLEN > 32) begin : g_word_sext
      assign w_word = {{(XLEN-32){r_rdata[31]}}, r_rdata[31:0]};
    end else begin : g_word_full
      assign w_word = r_rdata;
    end
  endgenerate

  // Any funct3 outside the byte/half encodings behaves as lw.
  always_comb begin
    w_load     = w_word;
    w_mis_cond = (w_off != 2'b00);
    case (r_funct3)
      c_F3_LB: begin
        w_load     = {{(XLEN-8){w_byte[7]}}, w_byte};
        w_mis_cond = 1'b0;
      end
      c_F3_LBU: begin
        w_load     = {{(XLEN-8){1'b0}}, w_byte};
        w_mis_cond = 1'b0;
      end
      c_F3_LH: begin
        w_load     = {{(XLEN-16){w_half[15]}}, w_half};
        w_mis_cond = w_off[0];
      end
      c_F3_LHU: begin
        w_load     = {{(XLEN-16){1'b0}}, w_half};
        w_mis_cond = w_off[0];
      end
      default: begin
        w_load     = w_word;
        w_mis_cond = (w_off != 2'b00);
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback select and register-file port.
  // ---------------------------------------------------------------------------
  assign w_misalign = r_valid & (r_resultsrc == c_SRC_LOAD) & w_mis_cond;
  assign w_we       = r_valid & r_regwrite & (r_rd != 5'd0) & ~w_misalign;

  always_comb begin
    w_sel = r_aluresult;
    case (r_resultsrc)
      c_SRC_ALU:  w_sel = r_aluresult;
      c_SRC_LOAD: w_sel = w_load;
      c_SRC_PC4:  w_sel = r_pcplus4;
      default:    w_sel = r_aluresult;
    endcase
  end

  assign bus.we3       = w_we;
  assign bus.a3        = w_we ? r_rd  : 5'd0;
  assign bus.wd3       = w_we ? w_sel : '0;
  assign bus.fwd_valid = bus.we3;
  assign bus.fwd_rd    = bus.a3;
  assign bus.fwd_data  = bus.wd3;
  assign bus.misalign  = w_misalign;

  // ---------------------------------------------------------------------------
  // Retire counter: an instruction retires once, on the edge its slot leaves.
  // ---------------------------------------------------------------------------
  assign w_advance = ~bus.stall | bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_valid && !w_misalign && w_advance) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Self-checking bench for wb_stage (vector table, corner
//             sequences, randomized traffic against a behavioural model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

  typedef struct {
    bit        valid;
    bit        rw;
    bit [4:0]  rd;
    bit [1:0]  rs;
    bit [2:0]  f3;
    bit [31:0] alu;
    bit [31:0] rdata;
    bit [31:0] pc4;
  } instr_t;

  typedef struct {
    instr_t    in;
    bit        we;
    bit [4:0]  a3;
    bit [31:0] wd;
    bit        mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .CNT_W(32)) u_if  ();
  wb_stage_if #(.XLEN(32), .CNT_W(3))  u_if2 ();

  wb_stage #(.XLEN(32), .CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n),  .bus(u_if.slave));
  wb_stage #(.XLEN(32), .CNT_W(3))  dut2 (.clk(clk), .rst_n(rst2_n), .bus(u_if2.slave));

  int          n_chk  = 0;
  int          n_pass = 0;
  instr_t      cur;
  bit          cur_stall, cur_flush;
  instr_t      slot;
  int unsigned mret;
  vec_t        vt[16];

  function automatic instr_t mk(bit v, bit rw, bit [4:0] rd, bit [1:0] rs, bit [2:0] f3,
                                bit [31:0] alu, bit [31:0] rdata, bit [31:0] pc4);
    instr_t t;
    t.valid = v; t.rw = rw; t.rd = rd; t.rs = rs; t.f3 = f3;
    t.alu = alu; t.rdata = rdata; t.pc4 = pc4;
    return t;
  endfunction

  function automatic vec_t mkv(instr_t i, bit we, bit [4:0] a3, bit [31:0] wd, bit mis);
    vec_t v;
    v.in = i; v.we = we; v.a3 = a3; v.wd = wd; v.mis = mis;
    return v;
  endfunction

  // Reference model: a load reads size bytes at byte address off of the word.
  function automatic bit m_mis(instr_t s);
    int off = int'(s.alu[1:0]);
    if (!s.valid || s.rs != 2'b01) return 1'b0;
    case (s.f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (off % 2) != 0;
      default:    return off != 0;
    endcase
  endfunction

  function automatic bit [31:0] m_load(instr_t s);
    int        off = int'(s.alu[1:0]);
    bit [31:0] b   = s.rdata >> (8 * off);
    bit [31:0] h   = s.rdata >> (8 * (off - (off % 2)));
    case (s.f3)
      3'd0:    return 32'($signed(b[7:0]));
      3'd4:    return {24'd0, b[7:0]};
      3'd1:    return 32'($signed(h[15:0]));
      3'd5:    return {16'd0, h[15:0]};
      default: return s.rdata;
    endcase
  endfunction

  function automatic bit m_we(instr_t s);
    return s.valid && s.rw && (s.rd != 5'd0) && !m_mis(s);
  endfunction

  function automatic bit [31:0] m_wd(instr_t s);
    if (!m_we(s)) return 32'd0;
    if (s.rs == 2'b01) return m_load(s);
    if (s.rs == 2'b10) return s.pc4;
    return s.alu;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(instr_t d, bit st, bit fl);
    cur = d; cur_stall = st; cur_flush = fl;
    u_if.stall       = st;
    u_if.flush       = fl;
    u_if.m_valid     = d.valid;
    u_if.m_regwrite  = d.rw;
    u_if.m_rd        = d.rd;
    u_if.m_resultsrc = d.rs;
    u_if.m_funct3    = d.f3;
    u_if.m_aluresult = d.alu;
    u_if.m_rdata     = d.rdata;
    u_if.m_pcplus4   = d.pc4;
  endtask

  task automatic model_reset();
    slot = mk(0, 0, 0, 0, 0, 0, 0, 0);
    mret = 0;
  endtask

  // One clock edge; the model advances with the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (slot.valid && !m_mis(slot) && (!cur_stall || cur_flush)) mret++;
      if (cur_flush)       slot.valid = 1'b0;
      else if (!cur_stall) slot = cur;
    end
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_we3"},      32'(u_if.we3),       32'(m_we(slot)));
    chk({tag, "_a3"},       32'(u_if.a3),        m_we(slot) ? 32'(slot.rd) : 32'd0);
    chk({tag, "_wd3"},      u_if.wd3,            m_wd(slot));
    chk({tag, "_misalign"}, 32'(u_if.misalign),  32'(m_mis(slot)));
    chk({tag, "_fwd_v"},    32'(u_if.fwd_valid), 32'(m_we(slot)));
    chk({tag, "_fwd_rd"},   32'(u_if.fwd_rd),    m_we(slot) ? 32'(slot.rd) : 32'd0);
    chk({tag, "_fwd_d"},    u_if.fwd_data,       m_wd(slot));
    chk({tag, "_retired"},  u_if.retired,        mret);
  endtask

  instr_t      bub;
  int unsigned base;

  initial begin
    bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    u_if2.stall = 1'b0; u_if2.flush = 1'b0;
    u_if2.m_valid = 1'b1; u_if2.m_regwrite = 1'b1; u_if2.m_rd = 5'd1;
    u_if2.m_resultsrc = 2'b00; u_if2.m_funct3 = 3'd0;
    u_if2.m_aluresult = 32'h11; u_if2.m_rdata = 32'h0; u_if2.m_pcplus4 = 32'h4;

    // Reset holds outputs at zero even with a live instruction presented.
    drive(mk(1, 1, 5, 0, 0, 32'h55, 0, 32'h8), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we3", 32'(u_if.we3), 32'd0);
    chk("rst_a3", 32'(u_if.a3), 32'd0);
    chk("rst_wd3", u_if.wd3, 32'd0);
    chk("rst_mis", 32'(u_if.misalign), 32'd0);
    chk("rst_retired", u_if.retired, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_we3", 32'(u_if.we3), 32'd1);
    chk("rel_a3", 32'(u_if.a3), 32'd5);
    check_model("rel");

    // Directed vectors, one instruction per cycle.
    vt[0]  = mkv(mk(1,1,3,0,0,32'h1234_5678,0,0),           1, 3, 32'h1234_5678, 0);
    vt[1]  = mkv(mk(1,1,4,2,0,32'h0,0,32'h104),             1, 4, 32'h0000_0104, 0);
    vt[2]  = mkv(mk(1,1,6,3,0,32'hABCD,0,32'h9),            1, 6, 32'h0000_ABCD, 0);
    vt[3]  = mkv(mk(1,1,8,1,0,32'h1003,32'h80FF_7F01,0),    1, 8, 32'hFFFF_FF80, 0);
    vt[4]  = mkv(mk(1,1,8,1,4,32'h1003,32'h80FF_7F01,0),    1, 8, 32'h0000_0080, 0);
    vt[5]  = mkv(mk(1,1,9,1,1,32'h1002,32'h80FF_7F01,0),    1, 9, 32'hFFFF_80FF, 0);
    vt[6]  = mkv(mk(1,1,9,1,5,32'h1000,32'h80FF_7F01,0),    1, 9, 32'h0000_7F01, 0);
    vt[7]  = mkv(mk(1,1,10,1,2,32'h1000,32'h80FF_7F01,0),   1, 10, 32'h80FF_7F01, 0);
    vt[8]  = mkv(mk(1,1,10,1,2,32'h1002,32'h80FF_7F01,0),   0, 0, 32'h0, 1);
    vt[9]  = mkv(mk(1,1,11,1,1,32'h1001,32'h80FF_7F01,0),   0, 0, 32'h0, 1);
    vt[10] = mkv(mk(1,1,0,0,0,32'hDEAD,0,0),                0, 0, 32'h0, 0);
    vt[11] = mkv(mk(0,1,12,0,0,32'hBEEF,0,0),               0, 0, 32'h0, 0);
    vt[12] = mkv(mk(1,0,13,0,0,32'hCAFE,0,0),               0, 0, 32'h0, 0);
    vt[13] = mkv(mk(1,1,14,1,0,32'h2001,32'h80FF_7F01,0),   1, 14, 32'h0000_007F, 0);
    vt[14] = mkv(mk(1,1,15,1,3,32'h2000,32'h80FF_7F01,0),   1, 15, 32'h80FF_7F01, 0);
    vt[15] = mkv(mk(1,1,16,1,6,32'h2002,32'h80FF_7F01,0),   0, 0, 32'h0, 1);
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].in, 1'b0, 1'b0);
      step();
      chk($sformatf("vec%0d_we3", i), 32'(u_if.we3), 32'(vt[i].we));
      chk($sformatf("vec%0d_a3", i), 32'(u_if.a3), 32'(vt[i].a3));
      chk($sformatf("vec%0d_wd3", i), u_if.wd3, vt[i].wd);
      chk($sformatf("vec%0d_mis", i), 32'(u_if.misalign), 32'(vt[i].mis));
      chk($sformatf("vec%0d_retired", i), u_if.retired, mret);
    end

    // Flush together with stall drops the MEM instruction.
    drive(bub, 1'b0, 1'b0);
    step();
    base = mret;
    drive(mk(1,1,9,0,0,32'h99,0,0), 1'b1, 1'b1);
    step();
    chk("flush_we3", 32'(u_if.we3), 32'd0);
    chk("flush_retired", u_if.retired, base);

    // Stall holds WB for three cycles; the instruction retires exactly once.
    drive(bub, 1'b0, 1'b0);
    step();
    drive(mk(1,1,7,0,0,32'h77,0,0), 1'b0, 1'b0);
    step();
    base = mret;
    chk("stall_cap_a3", 32'(u_if.a3), 32'd7);
    drive(mk(1,1,12,0,0,32'hC,0,0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_we3", i), 32'(u_if.we3), 32'd1);
      chk($sformatf("stall%0d_a3", i), 32'(u_if.a3), 32'd7);
      chk($sformatf("stall%0d_wd3", i), u_if.wd3, 32'h77);
      chk($sformatf("stall%0d_retired", i), u_if.retired, base);
    end
    drive(mk(1,1,12,0,0,32'hC,0,0), 1'b0, 1'b0);
    step();
    chk("unstall_a3", 32'(u_if.a3), 32'd12);
    chk("unstall_retired", u_if.retired, base + 1);

    // Asynchronous reset in the middle of a stall clears outputs immediately.
    drive(mk(1,1,10,0,0,32'hA0,0,0), 1'b0, 1'b0);
    step();
    drive(mk(1,1,10,0,0,32'hA0,0,0), 1'b1, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we3", 32'(u_if.we3), 32'd0);
    chk("arst_a3", 32'(u_if.a3), 32'd0);
    chk("arst_wd3", u_if.wd3, 32'd0);
    chk("arst_retired", u_if.retired, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(bub, 1'b0, 1'b0);
    step();
    check_model("post_arst");

    // Counter wrap on the narrow-counter instance.
    @(posedge clk);
    #1 rst2_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("wrap_pre", 32'(u_if2.retired), 32'd7);
    @(posedge clk);
    #1;
    chk("wrap_zero", 32'(u_if2.retired), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      instr_t r;
      r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom);
      drive(r, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
